mem_port_arbiter: RTL and testbench

Sequential arbiter and sequencer that shares the single synchronous memory port between the instruction-fetch requester (IF) and the data-access requester (DM: lw/sw, driven by MemEn/MemWrite from the control unit). It grants one transaction at a time and tracks the memory's fixed read latency. It returns read data to the granted requester and raises a busy/stall indication to the pipeline. It sits between the CPU core's fetch/memory stages and the SRAM wrapper.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory-port arbiter: FSM states, grant ids
// and the debug view of the arbiter's internal state.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_id_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  typedef struct packed {
    state_t    state;
    logic [1:0] lat_cnt;
    gnt_id_t   last_grant;
  } dbg_t;

  // Latency counter preload: counts READ_LAT-1 down to 0 inclusive.
  function automatic logic [1:0] lat_load(int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. gnt is combinational and one-hot; last_grant
// moves to the winner only on a cycle where a grant is actually given.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output gnt_id_t    last_grant
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Under contention the side not granted last time wins.
        2'b11:   gnt = (last_grant == GNT_IF) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= GNT_IF;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[1] ? GNT_DM : GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch (IF) and data (DM)
// requesters; issues one transaction at a time and returns read data after READ_LAT.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output dbg_t              dbg
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("mem_port_arbiter: READ_LAT must be within 1..4");
  end

  localparam logic [1:0] LAT_LOAD = lat_load(READ_LAT);

  state_t     state, state_nxt;
  logic [1:0] lat_cnt, lat_cnt_nxt;
  logic [1:0] gnt;
  gnt_id_t    last_grant;
  logic       final_cycle;
  logic       can_issue;
  logic       dm_is_read;
  logic       issue_read;

  // Valid/ready handshake: a requester holds req and its payload stable until
  // it sees ack high in a cycle; that cycle is the issue cycle on the memory port.
  assign final_cycle = (state != IDLE) && (lat_cnt == 2'd0);
  assign can_issue   = resetn && ((state == IDLE) || final_cycle);
  assign dm_is_read  = (dm_wen == 4'b0000);

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .resetn     (resetn),
    .req        ({dm_req, if_req}),
    .en         (can_issue),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  always_comb begin
    if_ack     = gnt[0];
    dm_ack     = gnt[1];
    mem_en     = gnt[0] | gnt[1];
    mem_wen    = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    issue_read = gnt[0] | (gnt[1] & dm_is_read);
    if (gnt[1]) begin
      mem_wen   = dm_wen;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (gnt[0]) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    if_rvalid = (state == RD_IF) && (lat_cnt == 2'd0);
    dm_rvalid = (state == RD_DM) && (lat_cnt == 2'd0);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    dm_rdata  = dm_rvalid ? mem_rdata : 32'h0;
    busy      = (state != IDLE) | issue_read;
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    if ((state != IDLE) && (lat_cnt != 2'd0)) begin
      lat_cnt_nxt = lat_cnt - 2'd1;
    end
    // Writes finish at issue, so an issued store leaves the FSM idle.
    if (can_issue) begin
      state_nxt = IDLE;
      if (gnt[0]) begin
        state_nxt   = RD_IF;
        lat_cnt_nxt = LAT_LOAD;
      end else if (gnt[1] && dm_is_read) begin
        state_nxt   = RD_DM;
        lat_cnt_nxt = LAT_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  assign dbg = '{state: state, lat_cnt: lat_cnt, last_grant: last_grant};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random and directed requests, a latency-pipelined
// SRAM model, a port-availability reference model and rvalid scoreboards.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 3;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack, if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req = 1'b0;
  logic [3:0]    dm_wen = 4'h0;
  logic [AW-1:0] dm_addr = '0;
  logic [31:0]   dm_wdata = 32'h0;
  logic          dm_ack, dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  dbg_t          dbg;

  mem_port_arbiter #(.READ_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model: data READ_LAT cycles after mem_en ----------------
  function automatic logic [31:0] pattern(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h3C1D_0000;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (mem_en && mem_wen == 4'h0) ? pattern(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];
  int          if_cyc_q[$];
  int          dm_cyc_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  gnt_id_t m_last = GNT_IF;
  int      m_free_at = 0;
  int      m_rd_end = -100;
  int      g_if = 0, g_dm = 0;
  logic    if_acked = 1'b0, dm_acked = 1'b0;

  initial begin
    forever begin
      logic          e_if, e_dm, e_rd;
      logic [AW-1:0] e_addr;
      logic [3:0]    e_wen;
      logic [31:0]   e_wd;
      @(negedge clk);
      if_acked = if_ack;
      dm_acked = dm_ack;
      if (!resetn) begin
        m_last = GNT_IF; m_free_at = 0; m_rd_end = -100;
        if_exp_q.delete(); if_cyc_q.delete();
        dm_exp_q.delete(); dm_cyc_q.delete();
        check("reset_ctrl", {if_ack, dm_ack, if_rvalid, dm_rvalid, mem_en, busy, mem_wen}, 64'h0);
        check("reset_data", {if_rdata, dm_rdata}, 64'h0);
        check("reset_mem", {mem_addr, mem_wdata}, 64'h0);
      end else begin
        e_if = 1'b0; e_dm = 1'b0;
        // Port is free once the previous read's data cycle has come.
        if (cyc >= m_free_at && (if_req || dm_req)) begin
          if (if_req && dm_req) begin
            e_dm = (m_last == GNT_IF);
            e_if = !e_dm;
          end else begin
            e_if = if_req;
            e_dm = dm_req;
          end
          m_last = e_dm ? GNT_DM : GNT_IF;
          if (e_if) g_if++;
          if (e_dm) g_dm++;
        end
        e_rd   = e_if || (e_dm && dm_wen == 4'h0);
        e_addr = e_dm ? dm_addr : (e_if ? if_addr : '0);
        e_wen  = e_dm ? dm_wen : 4'h0;
        e_wd   = e_dm ? dm_wdata : 32'h0;
        check("acks_en", {if_ack, dm_ack, mem_en}, {e_if, e_dm, e_if | e_dm});
        check("mem_addr", mem_addr, e_addr);
        check("mem_wen", mem_wen, e_wen);
        check("mem_wdata", mem_wdata, e_wd);
        check("busy", busy, (cyc <= m_rd_end) || e_rd);
        if (e_rd) begin
          m_rd_end  = cyc + LAT;
          m_free_at = cyc + LAT;
          if (e_if) begin
            if_exp_q.push_back(pattern(if_addr)); if_cyc_q.push_back(cyc + LAT);
          end else begin
            dm_exp_q.push_back(pattern(dm_addr)); dm_cyc_q.push_back(cyc + LAT);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (if_rvalid) begin
          if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
          else begin
            check("if_rdata", if_rdata, if_exp_q.pop_front());
            check("if_rvalid_cycle", 64'(cyc), 64'(if_cyc_q.pop_front()));
          end
        end else begin
          check("if_rdata_idle", if_rdata, 0);
          if (if_cyc_q.size() > 0 && if_cyc_q[0] <= cyc) begin
            check("if_rvalid_missing", 0, 1);
            void'(if_cyc_q.pop_front()); void'(if_exp_q.pop_front());
          end
        end
        if (dm_rvalid) begin
          if (dm_exp_q.size() == 0) check("dm_rvalid_unexpected", 1, 0);
          else begin
            check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
            check("dm_rvalid_cycle", 64'(cyc), 64'(dm_cyc_q.pop_front()));
          end
        end else begin
          check("dm_rdata_idle", dm_rdata, 0);
          if (dm_cyc_q.size() > 0 && dm_cyc_q[0] <= cyc) begin
            check("dm_rvalid_missing", 0, 1);
            void'(dm_cyc_q.pop_front()); void'(dm_exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(int p_if, int p_dm, int p_wr);
    @(posedge clk); #1;
    if (if_req && if_acked) if_req = 1'b0;
    if (dm_req && dm_acked) dm_req = 1'b0;
    if (!if_req && $urandom_range(0, 99) < p_if) begin
      if_req  = 1'b1;
      if_addr = 32'hBFC0_0000 + 32'($urandom_range(0, 1023)) * 4;
    end
    if (!dm_req && $urandom_range(0, 99) < p_dm) begin
      dm_req   = 1'b1;
      dm_addr  = $urandom & 32'hFFFF_FFFC;
      dm_wen   = ($urandom_range(0, 99) < p_wr) ? 4'($urandom_range(1, 15)) : 4'h0;
      dm_wdata = $urandom;
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    int diff;
    repeat (3) @(posedge clk);
    #1;
    // Contention right after reset: DM should win first.
    resetn = 1'b1;
    if_req = 1'b1; if_addr = 32'hBFC0_0000;
    dm_req = 1'b1; dm_wen = 4'h0; dm_addr = 32'h0000_0100;
    repeat (20) drive_cycle(0, 0, 0);

    // Single store: completes at issue, never busy.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_wen = 4'b0011; dm_addr = 32'h0000_0200; dm_wdata = 32'h1234_ABCD;
    repeat (10) drive_cycle(0, 0, 0);

    // Continuous fetch stream.
    repeat (16) drive_cycle(100, 0, 0);
    repeat (10) drive_cycle(0, 0, 0);

    // Both requesters saturated with DM reads: grants must alternate.
    g_if = 0; g_dm = 0;
    repeat (48) drive_cycle(100, 100, 0);
    diff = g_if - g_dm;
    check("rr_fairness", (g_if > 0 && g_dm > 0 && diff >= -1 && diff <= 1), 1);
    repeat (10) drive_cycle(0, 0, 0);

    repeat (600) drive_cycle(60, 60, 40);
    repeat (10) drive_cycle(0, 0, 0);

    // Reset one cycle after a fetch issue; the read must be dropped.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(posedge clk); #1;
    resetn = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #1;
    check("reset_async_busy", {busy, if_rvalid, mem_en}, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    dm_req = 1'b1; dm_wen = 4'h0; dm_addr = 32'h0000_0300;
    repeat (LAT * 3 + 4) drive_cycle(0, 0, 0);

    repeat (300) drive_cycle(50, 70, 30);
    repeat (12) drive_cycle(0, 0, 0);
    check("if_queue_drained", if_exp_q.size(), 0);
    check("dm_queue_drained", dm_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
